// File: rtl/graphpulse_pkg.sv
// graphpulse_pkg: shared memory-command encodings, tag-table entry type and arbiter states
`ifndef XLEN
`define XLEN 32
`endif
package graphpulse_pkg;
  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;
  localparam int NUM_TAGS = 16;
  localparam int OWNER_W  = 3;
  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
  } tag_entry_t;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_QUIET} state_t;
endpackage

// File: rtl/vertexmem_arbiter_if.sv
// vertexmem_arbiter_if: vertex-memory port; master is the arbiter, slave is the memory
interface vertexmem_arbiter_if #(
  parameter int ADDR_W = `XLEN
);
  logic [1:0]        mem_command;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_st_data;
  logic [1:0]        mem_size;
  logic [3:0]        mem_response;
  logic [63:0]       mem_ld_data;
  logic [3:0]        mem_tag;
  modport master (
    output mem_command, mem_addr, mem_st_data, mem_size,
    input  mem_response, mem_ld_data, mem_tag
  );
  modport slave (
    input  mem_command, mem_addr, mem_st_data, mem_size,
    output mem_response, mem_ld_data, mem_tag
  );
endinterface

// File: rtl/vertexmem_arbiter_rr_pick.sv
// rr_pick: round-robin picker; the first request at or after ptr (mod N) wins
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int W = $clog2(N);
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[W'((int'(ptr) + k) % N)]) begin
        idx = W'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/vertexmem_arbiter.sv
// vertexmem_arbiter: round-robin share of the vertex-memory port with tag-routed load completions
// Defining VMEM_ARB_STATS_EN adds saturating stat_grants/stat_rejects counters.
module vertexmem_arbiter
  import graphpulse_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = `XLEN
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [2*NUM_REQ-1:0]      req_command,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [64*NUM_REQ-1:0]     req_st_data,
  input  logic [2*NUM_REQ-1:0]      req_size,
  output logic [NUM_REQ-1:0]        req_accept,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [63:0]               resp_data,
  input  logic                      drain,
`ifdef VMEM_ARB_STATS_EN
  output logic [31:0]               stat_grants,
  output logic [31:0]               stat_rejects,
`endif
  output logic                      idle,
  vertexmem_arbiter_if.master       mem
);
  localparam int IDX_W = $clog2(NUM_REQ);
  state_t state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, g_idx;
  tag_entry_t [NUM_TAGS-1:0] tbl_q, tbl_d;
  logic [3:0] out_cnt_q, out_cnt_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d, pick_req, g_oh;
  logic [63:0] resp_data_q, resp_data_d;
  logic [1:0] g_cmd;
  logic pick_any, granted, accepted, ld_acc, cpl;

  rr_pick #(.N(NUM_REQ)) u_pick (.req(pick_req), .ptr(rr_ptr_q), .gnt(g_oh), .idx(g_idx), .any(pick_any));

  always_comb begin
    pick_req = '0;
    for (int i = 0; i < NUM_REQ; i++) pick_req[i] = req_valid[i] && req_command[2*i +: 2] != MEM_NONE;
    // the port stays at NONE while reset is held, even with requests pending
    granted = reset && state_q == ST_RUN && pick_any;
    g_cmd = req_command[2*int'(g_idx) +: 2];
    mem.mem_command = granted ? g_cmd : MEM_NONE;
    mem.mem_addr = granted ? req_addr[ADDR_W*int'(g_idx) +: ADDR_W] : '0;
    mem.mem_st_data = granted ? req_st_data[64*int'(g_idx) +: 64] : '0;
    mem.mem_size = granted ? req_size[2*int'(g_idx) +: 2] : '0;
    accepted = granted && mem.mem_response != '0;
    req_accept = accepted ? g_oh : '0;
    ld_acc = accepted && g_cmd == MEM_LOAD;
    cpl = mem.mem_tag != '0 && tbl_q[mem.mem_tag].valid;
    rr_ptr_d = accepted ? IDX_W'((int'(g_idx) + 1) % NUM_REQ) : rr_ptr_q;
    tbl_d = tbl_q;
    if (cpl) tbl_d[mem.mem_tag].valid = 1'b0;
    // allocate after retiring so a tag completed and reissued in one cycle ends up owned by the new requester
    if (ld_acc) tbl_d[mem.mem_response] = '{valid: 1'b1, owner: OWNER_W'(g_idx)};
    out_cnt_d = out_cnt_q + 4'(ld_acc) - 4'(cpl);
    resp_valid_d = cpl ? (NUM_REQ'(1) << tbl_q[mem.mem_tag].owner) : '0;
    resp_data_d = cpl ? mem.mem_ld_data : '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   state_d = drain ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_d = !drain ? ST_RUN : (out_cnt_q == '0 ? ST_QUIET : ST_DRAIN);
      ST_QUIET: state_d = drain ? ST_QUIET : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      rr_ptr_q <= '0;
      tbl_q <= '0;
      out_cnt_q <= '0;
      resp_valid_q <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tbl_q <= tbl_d;
      out_cnt_q <= out_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data = resp_data_q;
  assign idle = state_q == ST_QUIET;

`ifdef VMEM_ARB_STATS_EN
  logic [31:0] grants_q, grants_d, rejects_q, rejects_d;
  always_comb begin
    grants_d = (accepted && !(&grants_q)) ? grants_q + 32'd1 : grants_q;
    rejects_d = (granted && !accepted && !(&rejects_q)) ? rejects_q + 32'd1 : rejects_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grants_q <= '0;
      rejects_q <= '0;
    end else begin
      grants_q <= grants_d;
      rejects_q <= rejects_d;
    end
  end
  assign stat_grants = grants_q;
  assign stat_rejects = rejects_q;
`endif
endmodule

// File: tb/tb_vertexmem_arbiter.sv
// tb_vertexmem_arbiter: scenario tasks with a response scoreboard for vertexmem_arbiter
module tb_vertexmem_arbiter;
  import graphpulse_pkg::*;
  localparam int N  = 4;
  localparam int AW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req_valid, req_accept, resp_valid;
  logic [2*N-1:0] req_command, req_size;
  logic [AW*N-1:0] req_addr;
  logic [64*N-1:0] req_st_data;
  logic [63:0] resp_data;
  logic drain, idle;
`ifdef VMEM_ARB_STATS_EN
  logic [31:0] stat_grants, stat_rejects;
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    int          owner;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];

  vertexmem_arbiter_if #(.ADDR_W(AW)) mem_if ();

  vertexmem_arbiter #(.NUM_REQ(N), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_command(req_command), .req_addr(req_addr),
    .req_st_data(req_st_data), .req_size(req_size), .req_accept(req_accept),
    .resp_valid(resp_valid), .resp_data(resp_data), .drain(drain),
`ifdef VMEM_ARB_STATS_EN
    .stat_grants(stat_grants), .stat_rejects(stat_rejects),
`endif
    .idle(idle), .mem(mem_if)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_inputs();
    req_valid = '0;
    req_command = '0;
    req_addr = '0;
    req_st_data = '0;
    req_size = '0;
    drain = 1'b0;
    mem_if.mem_response = '0;
    mem_if.mem_ld_data = '0;
    mem_if.mem_tag = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] cmd, input logic [31:0] addr);
    req_valid[i] = 1'b1;
    req_command[2*i +: 2] = cmd;
    req_addr[AW*i +: AW] = addr;
    req_st_data[64*i +: 64] = {32'hC0DE_0000, addr};
    req_size[2*i +: 2] = 2'd3;
  endtask

  task automatic complete(input logic [3:0] tag, input logic [63:0] data, input int owner, input bit expect_resp);
    mem_if.mem_tag = tag;
    mem_if.mem_ld_data = data;
    if (expect_resp) sb.push_back('{cyc + 1, owner, data});
  endtask

  // advance one cycle, then retire any scoreboard entry due now
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      checks++;
      if (resp_valid !== (N'(1) << sb[0].owner) || resp_data !== sb[0].data) begin
        errors++;
        $display("FAIL resp_route: got valid=%b data=%h, want valid=%b data=%h", resp_valid, resp_data, N'(1) << sb[0].owner, sb[0].data);
      end
      void'(sb.pop_front());
    end else if (resp_valid !== '0) begin
      errors++;
      $display("FAIL resp_unexpected: got valid=%b data=%h, want valid=0", resp_valid, resp_data);
    end
    while (sb.size() != 0 && sb[0].due < cyc) begin
      errors++;
      $display("FAIL resp_missed: got nothing, want owner=%0d data=%h", sb[0].owner, sb[0].data);
      void'(sb.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    set_req(0, MEM_LOAD, 32'h40);
    mem_if.mem_response = 4'd1;
    tick();
    checks++;
    if (mem_if.mem_command !== MEM_NONE || mem_if.mem_addr !== '0 || mem_if.mem_st_data !== '0 || mem_if.mem_size !== '0) begin
      errors++;
      $display("FAIL reset_mem: got cmd=%0d addr=%h data=%h size=%0d, want all 0", mem_if.mem_command, mem_if.mem_addr, mem_if.mem_st_data, mem_if.mem_size);
    end
    checks++;
    if (req_accept !== '0 || resp_valid !== '0 || resp_data !== '0 || idle !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got accept=%b rvalid=%b rdata=%h idle=%b, want 0", req_accept, resp_valid, resp_data, idle);
    end
    clear_inputs();
    reset = 1'b1;
    tick();
    checks++;
    if (mem_if.mem_command !== MEM_NONE || idle !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got cmd=%0d idle=%b, want 0 0", mem_if.mem_command, idle);
    end
  endtask

  task automatic test_single_load();
    do_reset();
    set_req(0, MEM_LOAD, 32'h40);
    mem_if.mem_response = 4'd3;
    #1;
    checks++;
    if (mem_if.mem_command !== MEM_LOAD || mem_if.mem_addr !== 32'h40 || mem_if.mem_size !== 2'd3) begin
      errors++;
      $display("FAIL single_mem: got cmd=%0d addr=%h size=%0d, want 1 40 3", mem_if.mem_command, mem_if.mem_addr, mem_if.mem_size);
    end
    checks++;
    if (req_accept !== 4'b0001) begin
      errors++;
      $display("FAIL single_accept: got %b want 0001", req_accept);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (req_accept !== '0) begin
      errors++;
      $display("FAIL single_accept_pulse: got %b want 0000", req_accept);
    end
    tick();
    complete(4'd3, 64'hDEAD, 0, 1'b1);
    tick();
    clear_inputs();
    checks++;
    if (resp_valid !== 4'b0001 || resp_data !== 64'hDEAD) begin
      errors++;
      $display("FAIL single_resp: got valid=%b data=%h, want 0001 dead", resp_valid, resp_data);
    end
    tick();
  endtask

  task automatic test_fairness();
    int exp_g = 0;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, MEM_STORE, 32'h100 + i);
    mem_if.mem_response = 4'd1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (req_accept !== (N'(1) << exp_g) || mem_if.mem_addr !== 32'h100 + exp_g) begin
        errors++;
        $display("FAIL fairness_c%0d: got accept=%b addr=%h, want %b %h", c, req_accept, mem_if.mem_addr, N'(1) << exp_g, 32'h100 + exp_g);
      end
      tick();
      exp_g = (exp_g + 1) % N;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_rejection();
    do_reset();
    set_req(2, MEM_LOAD, 32'h200);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_accept !== '0 || mem_if.mem_command !== MEM_LOAD || mem_if.mem_addr !== 32'h200) begin
        errors++;
        $display("FAIL reject_c%0d: got accept=%b cmd=%0d addr=%h, want 0000 1 200", c, req_accept, mem_if.mem_command, mem_if.mem_addr);
      end
      tick();
    end
    mem_if.mem_response = 4'd5;
    #1;
    checks++;
    if (req_accept !== 4'b0100) begin
      errors++;
      $display("FAIL reject_then_accept: got %b want 0100", req_accept);
    end
    tick();
    clear_inputs();
    set_req(1, MEM_STORE, 32'h110);
    set_req(3, MEM_STORE, 32'h130);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_accept !== '0 || mem_if.mem_addr !== 32'h130) begin
        errors++;
        $display("FAIL reject_hold_c%0d: got accept=%b addr=%h, want 0000 130", c, req_accept, mem_if.mem_addr);
      end
      tick();
    end
    mem_if.mem_response = 4'd6;
    #1;
    checks++;
    if (req_accept !== 4'b1000) begin
      errors++;
      $display("FAIL reject_retry: got %b want 1000", req_accept);
    end
    tick();
    #1;
    checks++;
    if (req_accept !== 4'b0010) begin
      errors++;
      $display("FAIL reject_wrap: got %b want 0010", req_accept);
    end
    tick();
    clear_inputs();
    complete(4'd5, 64'h5555, 2, 1'b1);
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_tag_reuse();
    do_reset();
    set_req(1, MEM_LOAD, 32'h71);
    mem_if.mem_response = 4'd7;
    tick();
    clear_inputs();
    set_req(3, MEM_LOAD, 32'h73);
    mem_if.mem_response = 4'd7;
    complete(4'd7, 64'h7171, 1, 1'b1);
    #1;
    checks++;
    if (req_accept !== 4'b1000) begin
      errors++;
      $display("FAIL reuse_accept: got %b want 1000", req_accept);
    end
    tick();
    clear_inputs();
    checks++;
    if (dut.out_cnt_q !== 4'd1) begin
      errors++;
      $display("FAIL reuse_count: got %0d want 1", dut.out_cnt_q);
    end
    complete(4'd7, 64'h7373, 3, 1'b1);
    tick();
    clear_inputs();
    checks++;
    if (dut.out_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL reuse_count_end: got %0d want 0", dut.out_cnt_q);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, MEM_LOAD, 32'h300 + i);
    for (int k = 0; k < 10; k++) begin
      if (k < 8) mem_if.mem_response = 4'(k + 1);
      else begin
        req_valid = '0;
        mem_if.mem_response = '0;
      end
      if (k >= 2) complete(4'(k - 1), 64'h1000 + 64'(k - 1), (k - 2) % N, 1'b1);
      #1;
      if (k < 8) begin
        checks++;
        if (req_accept !== (N'(1) << (k % N))) begin
          errors++;
          $display("FAIL b2b_accept_k%0d: got %b want %b", k, req_accept, N'(1) << (k % N));
        end
      end
      tick();
    end
    clear_inputs();
    tick();
    checks++;
    if (dut.out_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 0", dut.out_cnt_q);
    end
  endtask

  task automatic test_drain();
    do_reset();
    set_req(0, MEM_LOAD, 32'h400);
    mem_if.mem_response = 4'd1;
    tick();
    clear_inputs();
    set_req(1, MEM_LOAD, 32'h410);
    mem_if.mem_response = 4'd2;
    tick();
    clear_inputs();
    set_req(2, MEM_STORE, 32'h420);
    mem_if.mem_response = 4'd3;
    drain = 1'b1;
    #1;
    checks++;
    if (req_accept !== 4'b0100) begin
      errors++;
      $display("FAIL drain_rise_grant: got %b want 0100", req_accept);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (mem_if.mem_command !== MEM_NONE || req_accept !== '0 || idle !== 1'b0) begin
        errors++;
        $display("FAIL drain_block_c%0d: got cmd=%0d accept=%b idle=%b, want 0 0000 0", c, mem_if.mem_command, req_accept, idle);
      end
      tick();
    end
    complete(4'd1, 64'hA1, 0, 1'b1);
    tick();
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle_one_left: got %b want 0", idle);
    end
    complete(4'd2, 64'hA2, 1, 1'b1);
    tick();
    mem_if.mem_tag = '0;
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle_early: got %b want 0", idle);
    end
    tick();
    checks++;
    if (idle !== 1'b1 || mem_if.mem_command !== MEM_NONE) begin
      errors++;
      $display("FAIL drain_idle_rise: got idle=%b cmd=%0d, want 1 0", idle, mem_if.mem_command);
    end
    drain = 1'b0;
    #1;
    checks++;
    if (idle !== 1'b1 || req_accept !== '0) begin
      errors++;
      $display("FAIL drain_quiet_hold: got idle=%b accept=%b, want 1 0000", idle, req_accept);
    end
    tick();
    checks++;
    if (idle !== 1'b0 || req_accept !== 4'b0100 || mem_if.mem_command !== MEM_STORE) begin
      errors++;
      $display("FAIL drain_resume: got idle=%b accept=%b cmd=%0d, want 0 0100 2", idle, req_accept, mem_if.mem_command);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      set_req(i, MEM_LOAD, 32'h500 + i);
      mem_if.mem_response = 4'(9 + i);
      tick();
    end
    clear_inputs();
    checks++;
    if (dut.out_cnt_q !== 4'd3) begin
      errors++;
      $display("FAIL midflight_pre: got %0d want 3", dut.out_cnt_q);
    end
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    checks++;
    if (dut.out_cnt_q !== 4'd0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL midflight_reset: got cnt=%0d rvalid=%b, want 0 0000", dut.out_cnt_q, resp_valid);
    end
    complete(4'd10, 64'hBAD, 1, 1'b0);
    tick();
    clear_inputs();
    checks++;
    if (resp_valid !== '0 || dut.out_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL midflight_stale_tag: got rvalid=%b cnt=%0d, want 0000 0", resp_valid, dut.out_cnt_q);
    end
    set_req(0, MEM_STORE, 32'h600);
    set_req(1, MEM_STORE, 32'h610);
    mem_if.mem_response = 4'd1;
    #1;
    checks++;
    if (req_accept !== 4'b0001) begin
      errors++;
      $display("FAIL midflight_ptr: got %b want 0001", req_accept);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_load();
    test_fairness();
    test_rejection();
    test_tag_reuse();
    test_back_to_back();
    test_drain();
    test_reset_midflight();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vertexmem_arbiter.md
# vertexmem_arbiter

Shares the single vertex-memory port of `GraphPulse` among `NUM_REQ` internal requesters (event processors, vertex updaters). Each cycle it picks one requester round-robin and forwards its command to memory. It records the memory-issued tag of every accepted load and routes each load completion back to the requester that owns that tag. A drain handshake lets the top-level convergence logic stop new traffic and wait until the port is quiescent.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_W`, default `` `XLEN ``: address width.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset; asserted at 0.
- `req_valid` input NUM_REQ: the requester holds a command.
- `req_command` input 2*NUM_REQ: per-requester command. 0 = NONE, 1 = LOAD, 2 = STORE.
- `req_addr` input ADDR_W*NUM_REQ: per-requester address.
- `req_st_data` input 64*NUM_REQ: per-requester store data.
- `req_size` input 2*NUM_REQ: per-requester access size.
- `req_accept` output NUM_REQ: one-hot pulse in the cycle memory accepts that requester's command.
- `resp_valid` output NUM_REQ: one-hot pulse carrying load data back to its owner.
- `resp_data` output 64: registered load data, shared by all requesters.
- `drain` input 1: stop granting new requests.
- `idle` output 1: `drain` is high and no loads are outstanding.
- `mem_command`, `mem_addr`, `mem_st_data`, `mem_size` outputs 2/ADDR_W/64/2: memory request.
- `mem_response` input 4: nonzero value is the tag of an accepted request; 0 means rejected.
- `mem_ld_data` input 64: load data returned by memory.
- `mem_tag` input 4: nonzero value is the tag of a completing load.

## Operation
- Round-robin pointer `rr_ptr` (log2 NUM_REQ bits).
  - Grant goes to the first `i` at or after `rr_ptr` (mod NUM_REQ) with `req_valid[i]` set and a command other than NONE.
  - The `mem_*` outputs are driven combinationally from the granted requester. With no grant, `mem_command` = NONE.
- Acceptance: in a granted cycle, `mem_response != 0` means accepted.
  - `req_accept[g]` = 1 combinationally in that cycle.
  - `rr_ptr` <= g+1 (wraps to 0).
  - On rejection `rr_ptr` holds, so the same requester retries first.
- Tag table: 15 entries, tags 1..15. Each entry holds a valid bit and an owner index.
  - An accepted LOAD sets `table[mem_response]` = {1, g}.
  - An accepted STORE records nothing.
- Completion: when `mem_tag != 0` and `table[mem_tag].valid`:
  - next cycle, `resp_valid[owner]` = 1 and `resp_data` = `mem_ld_data` (registered);
  - the entry is cleared.
  - A `mem_tag` that hits an invalid entry is ignored; no pulse is produced.
- Same tag completes and is re-issued in one cycle: the clear is applied first, then the allocation, so the entry ends up valid with the new owner.
- Outstanding count `out_cnt` (4 bits): +1 on an accepted load, −1 on a valid completion, unchanged when both happen.
- FSM:
  - RUN: grants enabled. Goes to DRAIN when `drain` = 1.
  - DRAIN: no grants, `mem_command` = NONE, completions still processed. Goes to QUIET when `out_cnt` = 0, or to RUN if `drain` = 0.
  - QUIET: `idle` = 1, no grants. Goes to RUN when `drain` = 0.
- Reset values:
  - state RUN, `rr_ptr` 0, table cleared, `out_cnt` 0;
  - `resp_valid` 0, `resp_data` 0, `req_accept` 0, `idle` 0;
  - `mem_command` NONE, `mem_addr` 0, `mem_st_data` 0, `mem_size` 0.
- Reset asserted mid-operation discards in-flight tags; later completions for those tags are ignored.

## Timing
- Request to memory: 0 cycles; `mem_*` is combinational from `req_*`.
- Accept pulse: same cycle as a nonzero `mem_response`.
- Completion to `resp_valid`: 1 cycle; `resp_data` is valid only while `resp_valid` is high.
- `drain` rise to grants blocked: next cycle; the grant in the cycle `drain` rises is still honored.
- `idle` rises one cycle after `out_cnt` reaches 0 in DRAIN. It falls the cycle after `drain` falls.
- Throughput: one request and one completion per cycle.

## Configuration
- `VMEM_ARB_STATS_EN`
  - Defined: adds outputs `stat_grants` (32 bits, counts accepted requests) and `stat_rejects` (32 bits, counts granted cycles with `mem_response` = 0). Both counters saturate at all-ones and clear on reset.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `graphpulse_pkg`: the `MEM_NONE`/`MEM_LOAD`/`MEM_STORE` encodings, `NUM_TAGS` = 16, and a `tag_entry_t` struct {valid, owner}.
- One sub-module, `rr_pick`: a parameterized round-robin priority picker with inputs {request vector, pointer} and outputs {grant one-hot, grant index, any}.
- The tag table, counter, FSM and response registers stay in the top module.

## Test plan
- Single load: req0 LOAD addr 0x40, `mem_response` = 3; later `mem_tag` = 3 with data 0xDEAD → `req_accept[0]` in the same cycle, then `resp_valid[0]` = 1 with `resp_data` = 0xDEAD one cycle after the completion.
- Fairness: all 4 requesters valid continuously, memory accepts every cycle → grant order 0,1,2,3,0; each `req_accept` pulses once per 4 cycles.
- Rejection: req2 only, `mem_response` = 0 for 3 cycles, then 5 → `rr_ptr` stays at 2, no accept for 3 cycles, then `req_accept[2]`.
- Tag reuse: `mem_tag` = 7 (owner 1) in the same cycle that req3 is accepted with tag 7 → `resp_valid[1]` next cycle; `table[7]` owner = 3; `out_cnt` unchanged.
- Drain: 2 loads outstanding, assert `drain` → `mem_command` = NONE from the next cycle, `idle` = 0 until both complete, `idle` = 1 one cycle after the last; deassert `drain` → grants resume.
- Reset mid-flight: 3 loads outstanding, pulse `reset` low, then `mem_tag` = an old tag → no `resp_valid`; `out_cnt` = 0.
